// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_ctrl
// Description : UART transmit framing controller. Accepts a parallel word on
//               Data_Valid while idle and serializes one frame on TX_OUT, one
//               bit per CLK cycle: start (0), data LSB first, optional parity
//               bit from the upstream parity calculator, then stop (1).
// Ports       : CLK           - bit clock
//               RST           - synchronous active-low reset
//               Data_Valid    - transmit request, sampled only when idle
//               Parallel_Data - word to transmit
//               Parity_Enable - 1 = frame carries a parity bit
//               Parity_Bit    - parity from the TX parity calculator
//               TX_OUT        - registered serial line, idles high
//               Busy          - registered, high while a frame is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_ctrl #(
    parameter int Data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [Data_Width-1:0] Parallel_Data,
    input  logic                  Parity_Enable,
    input  logic                  Parity_Bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int c_CNT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(Data_Width - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q,  state_d;
    logic [Data_Width-1:0]   shreg_q,  shreg_d;
    logic [c_CNT_W-1:0]      cnt_q,    cnt_d;
    logic                    par_q,    par_d;
    logic                    par_en_q, par_en_d;
    logic                    tx_out_q, tx_out_d;
    logic                    busy_q,   busy_d;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
        end
    end

    // The outputs are registered, so each branch computes the line value for
    // the state being entered: the bit on TX_OUT always belongs to state_q.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        tx_out_d = 1'b1;
        busy_d   = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (Data_Valid) begin
                    state_d  = S_START;
                    shreg_d  = Parallel_Data;
                    par_en_d = Parity_Enable;
                    tx_out_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                // The calculator registered this word at the acceptance
                // edge; freeze its result now so later Data_Valid pulses
                // that re-load the calculator cannot corrupt the frame.
                par_d    = Parity_Bit;
                state_d  = S_DATA;
                cnt_d    = '0;
                tx_out_d = shreg_q[0];
                shreg_d  = shreg_q >> 1;
            end
            S_DATA: begin
                // cnt_q is the index of the data bit currently on the line.
                if (cnt_q == c_LAST_BIT) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        state_d  = S_PARITY;
                        tx_out_d = par_q;
                    end else begin
                        state_d  = S_STOP;
                    end
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    tx_out_d = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame_ctrl
// Description : Self-checking bench for uart_tx_frame_ctrl with a behavioural
//               parity calculator upstream and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dv;
    logic [W-1:0] pdata;
    logic         pen;
    logic         ptype;
    logic         pbit;
    logic         tx_out;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Parity calculator: registers parity of the word on every Data_Valid edge,
    // including pulses that arrive mid-frame.
    always @(posedge clk) begin
        if (!rst_n)  pbit <= 1'b0;
        else if (dv) pbit <= (^pdata) ^ ptype;
    end

    uart_tx_frame_ctrl #(.Data_Width(W)) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .Data_Valid    (dv),
        .Parallel_Data (pdata),
        .Parity_Enable (pen),
        .Parity_Bit    (pbit),
        .TX_OUT        (tx_out),
        .Busy          (busy)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop.
    function automatic void build_frame(input logic [W-1:0] d, input logic en,
                                        input logic typ, output logic fr[$]);
        fr = {};
        fr.push_back(1'b0);
        for (int i = 0; i < W; i++) fr.push_back(d[i]);
        if (en) fr.push_back((^d) ^ typ);
        fr.push_back(1'b1);
    endfunction

    task automatic start(input logic [W-1:0] d, input logic en, input logic typ);
        @(negedge clk);
        dv    = 1'b1;
        pdata = d;
        pen   = en;
        ptype = typ;
    endtask

    // Checks every cycle of a frame whose acceptance edge is the next posedge,
    // then the idle cycle after it. interfere drives a mid-frame request during
    // the data bits; keep_dv holds Data_Valid high with next_d for back-to-back.
    task automatic frame_body(input logic [W-1:0] d, input logic en, input logic typ,
                              input bit interfere, input bit keep_dv,
                              input logic [W-1:0] next_d);
        logic fr[$];
        build_frame(d, en, typ, fr);
        for (int k = 0; k < fr.size(); k++) begin
            @(negedge clk);
            check($sformatf("tx[%0d] d=%h", k, d), tx_out, fr[k]);
            check($sformatf("busy[%0d] d=%h", k, d), busy, 1'b1);
            if (keep_dv) begin
                if (k == 0) pdata = next_d;
            end else if (interfere && k >= 1 && k <= W - 1) begin
                dv    = 1'b1;
                pdata = 8'hFF;
                pen   = ~pen;
            end else begin
                dv = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("idle tx d=%h", d), tx_out, 1'b1);
        check($sformatf("idle busy d=%h", d), busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         ren;
        logic         rtyp;
        logic         fr[$];

        // Reset held low with a pending request: nothing may start.
        rst_n = 1'b0; dv = 1'b1; pdata = 8'hA5; pen = 1'b1; ptype = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset tx", tx_out, 1'b1);
            check("reset busy", busy, 1'b0);
        end
        rst_n = 1'b1; dv = 1'b0;
        @(negedge clk);
        check("post-reset tx", tx_out, 1'b1);
        check("post-reset busy", busy, 1'b0);

        // Even parity, odd parity, no parity.
        start(8'hA5, 1'b1, 1'b0); frame_body(8'hA5, 1'b1, 1'b0, 0, 0, '0);
        start(8'hA5, 1'b1, 1'b1); frame_body(8'hA5, 1'b1, 1'b1, 0, 0, '0);
        start(8'h3C, 1'b0, 1'b0); frame_body(8'h3C, 1'b0, 1'b0, 0, 0, '0);

        // Mid-frame interference must leave the even-parity frame untouched.
        start(8'hA5, 1'b1, 1'b0); frame_body(8'hA5, 1'b1, 1'b0, 1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no 2nd frame tx", tx_out, 1'b1);
            check("no 2nd frame busy", busy, 1'b0);
        end

        // Reset during data bit 3 aborts the frame on that edge.
        start(8'hA5, 1'b1, 1'b0);
        build_frame(8'hA5, 1'b1, 1'b0, fr);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("pre-abort tx[%0d]", k), tx_out, fr[k]);
            if (k == 0) dv = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort tx", tx_out, 1'b1);
        check("abort busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after abort tx", tx_out, 1'b1);
        start(8'h01, 1'b1, 1'b0); frame_body(8'h01, 1'b1, 1'b0, 0, 0, '0);

        // Back-to-back with Data_Valid held high.
        start(8'h55, 1'b1, 1'b0);
        frame_body(8'h55, 1'b1, 1'b0, 0, 1, 8'hAA);
        frame_body(8'hAA, 1'b1, 1'b0, 0, 0, '0);

        // Randomized frames with random idle gaps.
        for (int n = 0; n < 12; n++) begin
            rd   = W'($urandom);
            ren  = 1'($urandom_range(0, 1));
            rtyp = 1'($urandom_range(0, 1));
            start(rd, ren, rtyp);
            frame_body(rd, ren, rtyp, 1'($urandom_range(0, 1)), 0, '0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rand gap tx", tx_out, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
